// File: rtl/mbgd_pkg.sv
// Shared configuration, derived widths, FSM encoding and the theta saturation helper
// for the mini-batch gradient descent update block.
package mbgd_pkg;

  localparam int DW       = 8;
  localparam int N        = 8;
  localparam int N_bit    = 3;
  localparam int BATCH    = 4;
  localparam int B_bit    = 2;
  localparam int LR_SHIFT = 3;

  // err*x needs 2*DW+1 bits; BATCH additions add B_bit more, so no overflow is possible.
  localparam int ERR_W = DW + 1;
  localparam int ACC_W = 2 * DW + 1 + B_bit;
  localparam int SHIFT = DW + B_bit + LR_SHIFT;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic [DW-1:0] sat_theta(input logic signed [DW:0] v);
    if (v > $signed({2'b00, {(DW-1){1'b1}}}))
      return {1'b0, {(DW-1){1'b1}}};
    else if (v < $signed({2'b11, {(DW-1){1'b0}}}))
      return {1'b1, {(DW-1){1'b0}}};
    else
      return v[DW-1:0];
  endfunction

endpackage

// File: rtl/mbgd_grad_acc.sv
// One gradient accumulator lane: acc += err * x on add_i, synchronous clear on clr_i
// (clear wins). The caller gates add_i and clr_i with enable where needed.
module mbgd_grad_acc
  import mbgd_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clr_i,
  input  logic                    add_i,
  input  logic signed [ERR_W-1:0] err_i,
  input  logic        [DW-1:0]    x_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*DW:0]    prod;

  assign prod  = err_i * $signed(x_i);
  assign acc_o = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (add_i)
      acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

endmodule

// File: rtl/mbgd_theta_update.sv
// Gradient accumulate + serial theta update for mini-batch gradient descent.
// Define MBGD_THETA_SAT_EN to saturate theta updates instead of wrapping.
module mbgd_theta_update
  import mbgd_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              load_teta,
  input  logic [DW*N-1:0]   teta_init,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW*N-1:0]   x,
  input  logic [DW-1:0]     h,
  input  logic [DW-1:0]     y,
  output logic [DW*N-1:0]   teta,
  output logic              upd_done,
  output logic [1:0]        dbg_state_o
);

  logic [1:0]              state_q, state_d;
  logic [B_bit-1:0]        cnt_q, cnt_d;
  logic [N_bit-1:0]        idx_q, idx_d;
  logic [DW*N-1:0]         theta_q, theta_d;
  logic signed [ERR_W-1:0] err;
  logic signed [ACC_W-1:0] acc [N];
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [DW:0]      delta;
  logic signed [DW:0]      diff;
  logic [DW-1:0]           theta_sel;
  logic [DW-1:0]           theta_new;
  logic [N-1:0]            clr_vec;
  logic                    accept;
  logic                    upd_fire;

  // Handshake: a sample transfers on a rising edge where s_valid && s_ready; s_ready is
  // combinational, high only in ACCUM with enable high and no load_teta, and never
  // depends on s_valid.
  assign s_ready     = (state_q == ST_ACCUM) && enable && !load_teta;
  assign accept      = s_valid && s_ready;
  assign upd_fire    = (state_q == ST_UPDATE) && enable && !load_teta;
  assign upd_done    = (state_q == ST_DONE) && enable && !load_teta;
  assign teta        = theta_q;
  assign dbg_state_o = state_q;

  assign err = $signed({1'b0, h}) - $signed({1'b0, y});

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign clr_vec[i] = load_teta || (upd_fire && (idx_q == N_bit'(i)));

    mbgd_grad_acc u_acc (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (clr_vec[i]),
      .add_i  (accept),
      .err_i  (err),
      .x_i    (x[DW*i +: DW]),
      .acc_o  (acc[i])
    );
  end

  // The shifted accumulator always fits DW+1 bits, so theta - delta is exact at DW+1 bits.
  assign acc_sel   = acc[idx_q];
  assign delta     = (DW+1)'(acc_sel >>> SHIFT);
  assign theta_sel = theta_q[DW*idx_q +: DW];
  assign diff      = $signed({theta_sel[DW-1], theta_sel}) - delta;

`ifdef MBGD_THETA_SAT_EN
  assign theta_new = sat_theta(diff);
`else
  assign theta_new = DW'(diff);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    theta_d = theta_q;
    if (load_teta) begin
      theta_d = teta_init;
      cnt_d   = '0;
      idx_d   = '0;
      state_d = ST_ACCUM;
    end else if (enable) begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            if (cnt_q == B_bit'(BATCH - 1)) begin
              cnt_d   = '0;
              state_d = ST_UPDATE;
            end else begin
              cnt_d = cnt_q + B_bit'(1);
            end
          end
        end
        ST_UPDATE: begin
          theta_d[DW*idx_q +: DW] = theta_new;
          if (idx_q == N_bit'(N - 1)) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + N_bit'(1);
          end
        end
        ST_DONE: state_d = ST_ACCUM;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      theta_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      theta_q <= theta_d;
    end
  end

endmodule

// File: doc/mbgd_theta_update.md
Name: mbgd_theta_update

Overview:
Backward/update half of the mini-batch gradient descent datapath. It consumes per-sample results from the forward pass (feature vector x, prediction h, label y) and accumulates the gradient (h-y)*x[i] over BATCH samples. It then applies theta[i] -= grad[i]*2^-(DW+B_bit+LR_SHIFT) serially, one element per cycle. It owns the theta register that drives the forward pass's teta input.

Parameters:
DW, 8, element width (x, theta signed; h, y unsigned Q0.DW)
N, 8, vector length
N_bit, 3, log2(N), width of element index
BATCH, 4, samples per mini-batch (power of two)
B_bit, 2, log2(BATCH)
LR_SHIFT, 3, learning-rate right shift

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
enable  in  1  global advance; low freezes FSM, counters, accumulators, theta
load_teta  in  1  one-cycle pulse: load theta from teta_init, clear accumulators, enter ACCUM
teta_init  in  DW*N  initial theta, element i at [DW*i +: DW]
s_valid  in  1  sample valid
s_ready  out  1  block accepts sample
x  in  DW*N  sample features, signed, element i at [DW*i +: DW]
h  in  DW  forward prediction, unsigned
y  in  DW  label, unsigned
teta  out  DW*N  current theta register, signed
upd_done  out  1  one-cycle pulse when the batch update completes

Behaviour:
- Reset:
  - state=IDLE; theta, accumulators, sample count, element index = 0.
  - s_ready=0, upd_done=0, teta=0.
- States: IDLE, ACCUM, UPDATE, DONE.
- IDLE: s_ready=0. load_teta -> ACCUM.
- ACCUM:
  - s_ready=enable.
  - A sample is accepted when s_valid&&s_ready.
  - On accept: err=$signed({1'b0,h})-$signed({1'b0,y}) (DW+1 bits); acc[i]+=err*x[i] for all i in parallel.
  - Each acc[i] is 2*DW+1+B_bit bits signed; no overflow is possible.
  - The BATCH-th accept -> UPDATE, sample count reset to 0.
- UPDATE:
  - s_ready=0.
  - Each enabled cycle, element idx: delta=acc[idx]>>>(DW+B_bit+LR_SHIFT) (arithmetic, floor); theta[idx]<=theta[idx]-delta; acc[idx]<=0; idx++.
  - After idx=N-1 -> DONE, idx=0.
  - Takes exactly N enabled cycles.
- DONE: upd_done=1 for one cycle; -> ACCUM.
- Latency: last accept at edge T; theta[i] written at edge T+1+i; upd_done high during the cycle after edge T+N.
- teta is driven directly by the theta register (visible as elements update); consumers sample on upd_done.
- enable=0: no state/counter/register changes; s_ready=0; upd_done held low and re-asserts on the next enabled DONE cycle.
- load_teta has priority in every state, including mid-UPDATE and DONE, and regardless of enable:
  - theta<=teta_init; all acc, count, idx cleared; next state ACCUM; upd_done=0 that cycle.
  - A sample presented in the same cycle is not accepted (s_ready=0 when load_teta=1).
- Asynchronous reset mid-operation discards the partial batch; IDLE requires a new load_teta.

Optional Feature:
MBGD_THETA_SAT_EN
- Defined: theta[idx]-delta is computed at DW+1 bits and saturated to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: the result is truncated to DW bits (two's-complement wrap).

Decomposition:
- Package mbgd_pkg:
  - Widths ACC_W=2*DW+1+B_bit, ERR_W=DW+1, SHIFT=DW+B_bit+LR_SHIFT.
  - State enum {IDLE,ACCUM,UPDATE,DONE}.
  - Saturate function.
- One sub-module, mbgd_grad_acc: per-element multiply-accumulate with clear, instantiated N times.

Test Plan:
- Descent, positive gradient: theta init all 10, 4 samples x all 64, h=255, y=0 -> acc=65280, delta=7, teta all 3, upd_done 9 cycles after the last accept.
- Ascent, negative gradient: theta init all 10, x all 64, h=0, y=255 -> delta=-8, teta all 18.
- Saturation: theta init all -120, x all 127, h=255, y=0 -> delta=15. With MBGD_THETA_SAT_EN, teta all -128 (0x80). Without it, teta all 121 (0x79).
- Handshake/stall:
  - s_valid toggled randomly and enable low for 3 cycles mid-ACCUM and mid-UPDATE.
  - Result identical to the descent case.
  - s_ready=0 throughout UPDATE, DONE and enable-low cycles.
- load_teta at UPDATE idx=3: theta=teta_init exactly, acc cleared, no upd_done pulse. The next full batch gives the same result as a fresh start.
- Reset mid-ACCUM after 2 samples:
  - All outputs 0, state IDLE, s_ready=0 until load_teta.
  - 4 new samples then yield the expected values with no residue from the partial batch.
